router_src_arbiter: RTL and testbench

- Store-and-forward input arbiter placed in front of router_top's single input port.
- Shares the router input among 3 packet sources, granting round-robin at packet granularity.
- Buffers one whole packet (header, payload, parity) from the granted source, then replays it to the router, pausing whenever busy is high.
- Drops packets addressed to the unused port and flags parity mismatches.

---
 rtl/router_src_arbiter_if.sv | 24 ++
 rtl/router_src_arbiter.sv | 168 ++++++++++++++++
 tb/tb_router_src_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/router_src_arbiter_if.sv
// Source-side and router-side signals of the source arbiter, bundled.
// master: the sources and router environment; slave: the arbiter itself.
interface router_src_arbiter_if;
  logic [2:0]  src_valid;
  logic [23:0] src_data;
  logic [2:0]  src_ready;
  logic        busy;
  logic [7:0]  rtr_data;
  logic        rtr_pkt_valid;
  logic [1:0]  grant;
  logic        pkt_done;
  logic        drop;
  logic        par_err;

  modport master (
    output src_valid, src_data, busy,
    input  src_ready, rtr_data, rtr_pkt_valid, grant, pkt_done, drop, par_err
  );

  modport slave (
    input  src_valid, src_data, busy,
    output src_ready, rtr_data, rtr_pkt_valid, grant, pkt_done, drop, par_err
  );
endinterface

// File: rtl/router_src_arbiter.sv
// Store-and-forward arbiter sharing one router input among three sources.
// A whole packet is captured from the granted source, then replayed to the
// router while honouring busy. Packets to DROP_ADDR are swallowed.
module router_src_arbiter #(
  parameter int         GAP_CYCLES = 1,
  parameter logic [1:0] DROP_ADDR  = 2'd3
) (
  input logic             clock,
  input logic             reset,
  router_src_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

  localparam logic [1:0] GAP_INIT = 2'(GAP_CYCLES - 1);

  state_t     state;
  logic [1:0] grant_q;
  logic [1:0] last_grant;
  logic [2:0] ready_q;
  logic [7:0] rtr_data_q;
  logic       rtr_vld_q;
  logic       pkt_done_q;
  logic       drop_q;
  logic       par_err_q;
  logic [6:0] wptr;
  logic [6:0] rptr;
  logic [1:0] gap_cnt;

  logic [7:0] pkt_mem [0:64];
  logic [5:0] len;
  logic [1:0] addr;
  logic [7:0] par_acc;

  logic       xfer;
  logic [7:0] in_byte;
  logic [6:0] last_idx;
  logic [6:0] rptr_nxt;
  logic [1:0] winner;

  // First requester strictly after the previous owner, order 0->1->2->0.
  function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
    logic [1:0] pick;
    pick = 2'd0;
    case (last)
      2'd0:    pick = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    pick = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: pick = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
    return pick;
  endfunction

  assign winner   = rr_pick(bus.src_valid, last_grant);
  // src_ready is one-hot on the owner during LOAD only, so this is the transfer strobe.
  assign xfer     = |(bus.src_valid & ready_q);
  assign last_idx = {1'b0, len} + 7'd1;
  assign rptr_nxt = rptr + 7'd1;

  // Byte lane of the current owner.
  always_comb begin
    in_byte = bus.src_data[23:16];
    case (grant_q)
      2'd0:    in_byte = bus.src_data[7:0];
      2'd1:    in_byte = bus.src_data[15:8];
      default: in_byte = bus.src_data[23:16];
    endcase
  end

  // Packet capture: buffer, header fields and running parity (data path, no reset).
  always_ff @(posedge clock) begin
    if (state == IDLE) begin
      par_acc <= '0;
    end else if (xfer) begin
      pkt_mem[wptr] <= in_byte;
      par_acc       <= par_acc ^ in_byte;
      if (wptr == 7'd0) begin
        len  <= in_byte[7:2];
        addr <= in_byte[1:0];
      end
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant_q    <= 2'd3;
      last_grant <= 2'd2;
      ready_q    <= '0;
      rtr_data_q <= '0;
      rtr_vld_q  <= 1'b0;
      pkt_done_q <= 1'b0;
      drop_q     <= 1'b0;
      par_err_q  <= 1'b0;
      wptr       <= '0;
      rptr       <= '0;
      gap_cnt    <= '0;
    end else begin
      pkt_done_q <= 1'b0;
      drop_q     <= 1'b0;
      par_err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (|bus.src_valid) begin
            grant_q <= winner;
            ready_q <= 3'b001 << winner;
            wptr    <= '0;
            state   <= LOAD;
          end
        end
        LOAD: begin
          if (xfer) begin
            wptr <= wptr + 7'd1;
            // The header is never the parity byte; len is valid from wptr 1 on.
            if (wptr != 7'd0 && wptr == last_idx) begin
              ready_q   <= '0;
              par_err_q <= (par_acc != in_byte);
              if (addr == DROP_ADDR) begin
                drop_q     <= 1'b1;
                gap_cnt    <= GAP_INIT;
                last_grant <= grant_q;
                grant_q    <= 2'd3;
                state      <= GAP;
              end else begin
                rptr       <= '0;
                rtr_data_q <= pkt_mem[0];
                rtr_vld_q  <= 1'b1;
                state      <= SEND;
              end
            end
          end
        end
        SEND: begin
          if (!bus.busy) begin
            if (rptr == last_idx) begin
              pkt_done_q <= 1'b1;
              rtr_data_q <= '0;
              rtr_vld_q  <= 1'b0;
              gap_cnt    <= GAP_INIT;
              last_grant <= grant_q;
              grant_q    <= 2'd3;
              state      <= GAP;
            end else begin
              // Present the byte the pointer advances to; parity goes out with valid low.
              rptr       <= rptr_nxt;
              rtr_data_q <= pkt_mem[rptr_nxt];
              rtr_vld_q  <= (rptr_nxt <= {1'b0, len});
            end
          end
        end
        GAP: begin
          if (gap_cnt == 2'd0) state <= IDLE;
          else                 gap_cnt <= gap_cnt - 2'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.src_ready     = ready_q;
  assign bus.rtr_data      = rtr_data_q;
  assign bus.rtr_pkt_valid = rtr_vld_q;
  assign bus.grant         = grant_q;
  assign bus.pkt_done      = pkt_done_q;
  assign bus.drop          = drop_q;
  assign bus.par_err       = par_err_q;

endmodule

// File: tb/tb_router_src_arbiter.sv
// Scoreboard bench for router_src_arbiter: sources replay queued packets,
// a round-robin reference predicts load order and router traffic.
module tb_router_src_arbiter;

  localparam int GAP = 1;

  typedef struct packed {
    logic [1:0]   src;
    logic [6:0]   n;
    logic         perr;
    logic         drp;
    logic [519:0] b;
  } pkt_t;

  logic clk;
  logic rst;
  router_src_arbiter_if bus();

  router_src_arbiter #(.GAP_CYCLES(GAP), .DROP_ADDR(2'd3)) dut (
    .clock(clk),
    .reset(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] sq [3][$];
  pkt_t stage [3][$];
  pkt_t exp_load [$];
  pkt_t exp_rtr [$];
  int  model_last = 2;
  bit  gaps = 0;
  int  busy_mode = 0;
  bit  strict = 0;
  int  phase = 0;

  bit  in_pkt = 0;
  bit  done_due = 0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic pkt_t mk_pkt(input int src, input logic [5:0] len, input logic [1:0] addr,
                                  input bit corrupt);
    pkt_t p;
    logic [7:0] x;
    logic [7:0] by;
    p = '0;
    p.src = 2'(src);
    p.n = 7'(len) + 7'd2;
    x = {len, addr};
    p.b[7:0] = x;
    for (int i = 1; i <= int'(len); i++) begin
      by = 8'($urandom);
      p.b[8*i +: 8] = by;
      x = x ^ by;
    end
    if (corrupt) x = x ^ 8'h01;
    p.b[8*(int'(len)+1) +: 8] = x;
    p.perr = corrupt;
    p.drp = (addr == 2'd3);
    return p;
  endfunction

  task automatic add_pkt(input pkt_t p);
    stage[p.src].push_back(p);
    for (int i = 0; i < int'(p.n); i++) sq[p.src].push_back(p.b[8*i +: 8]);
  endtask

  // Reference arbitration: every source with packets left keeps requesting,
  // so the owner order is plain round-robin over non-empty source lists.
  task automatic commit();
    pkt_t p;
    bit any;
    int s;
    any = 1;
    while (any) begin
      any = 0;
      for (int k = 1; k <= 3 && !any; k++) begin
        s = (model_last + k) % 3;
        if (stage[s].size() > 0) begin
          p = stage[s].pop_front();
          model_last = s;
          exp_load.push_back(p);
          if (!p.drp) exp_rtr.push_back(p);
          any = 1;
        end
      end
    end
  endtask

  // Source models: hold each header until taken, optional gaps inside a packet.
  initial begin
    int pos [3];
    bit took [3];
    logic [7:0] hb;
    logic [7:0] tmp;
    logic [7:0] d;
    bit v;
    for (int i = 0; i < 3; i++) begin pos[i] = 0; took[i] = 0; end
    bus.src_valid = '0;
    bus.src_data = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (rst) begin
          pos[i] = 0;
          took[i] = 0;
        end else if (took[i]) begin
          pos[i]++;
          hb = sq[i][0];
          if (pos[i] == int'(hb[7:2]) + 2) begin
            repeat (pos[i]) tmp = sq[i].pop_front();
            pos[i] = 0;
          end
        end
        v = 0;
        d = 8'($urandom);
        if (sq[i].size() > 0) begin
          v = (pos[i] == 0 || !gaps) ? 1'b1 : ($urandom_range(0, 3) != 0);
          if (v) d = sq[i][pos[i]];
        end
        bus.src_valid[i] = v;
        bus.src_data[8*i +: 8] = d;
      end
      for (int i = 0; i < 3; i++) took[i] = bus.src_valid[i] && bus.src_ready[i] && !rst;
    end
  end

  // Router busy: off, random, or a single 3-cycle stall at byte 5 of a packet.
  initial begin
    bit fired;
    fired = 0;
    bus.busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (busy_mode == 1) begin
        bus.busy = ($urandom_range(0, 4) == 0);
      end else if (busy_mode == 2) begin
        bus.busy = 1'b0;
        if (!fired && bus.rtr_pkt_valid) begin
          fired = 1;
          repeat (5) begin @(posedge clk); #1; end
          bus.busy = 1'b1;
          repeat (3) begin @(posedge clk); #1; end
          bus.busy = 1'b0;
        end
      end else begin
        bus.busy = 1'b0;
        fired = 0;
      end
    end
  end

  function automatic int ready_idx(input logic [2:0] r);
    return r[0] ? 0 : (r[1] ? 1 : 2);
  endfunction

  // Monitor: pops the expected load events and router packets as the DUT presents them.
  initial begin
    pkt_t e;
    pkt_t cur;
    logic [2:0] prev_ready;
    bit exp_done;
    int idx;
    int cyc;
    int last_hdr;
    int last_n;
    int prev_phase;
    bit have_prev;
    prev_ready = '0;
    idx = 0;
    cyc = 0;
    last_hdr = 0;
    last_n = 0;
    prev_phase = -1;
    have_prev = 0;
    cur = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        check_eq("reset_outputs",
                 {bus.src_ready, bus.rtr_data, bus.rtr_pkt_valid, bus.grant,
                  bus.pkt_done, bus.drop, bus.par_err},
                 {3'b000, 8'h00, 1'b0, 2'd3, 3'b000});
        in_pkt = 0;
        done_due = 0;
        prev_ready = '0;
        have_prev = 0;
        continue;
      end
      exp_done = done_due;
      done_due = 0;
      if (bus.pkt_done || exp_done) check_eq("pkt_done", bus.pkt_done, exp_done);

      if (bus.src_ready != 3'b000) begin
        check_eq("ready_onehot", $onehot(bus.src_ready), 1);
        if (prev_ready == 3'b000) check_eq("grant_at_load", bus.grant, ready_idx(bus.src_ready));
      end
      if (prev_ready != 3'b000 && bus.src_ready == 3'b000) begin
        if (exp_load.size() == 0) begin
          check_eq("load_unexpected", prev_ready, 0);
        end else begin
          e = exp_load.pop_front();
          check_eq("grant_order", ready_idx(prev_ready), e.src);
          check_eq("load_end_perr_drop", {bus.par_err, bus.drop}, {e.perr, e.drp});
          check_eq("grant_after_load", bus.grant, e.drp ? 2'd3 : e.src);
        end
      end else if (bus.par_err || bus.drop) begin
        check_eq("stray_pulse", {bus.par_err, bus.drop}, 0);
      end
      prev_ready = bus.src_ready;

      if (!in_pkt && bus.rtr_pkt_valid) begin
        if (exp_rtr.size() == 0) begin
          check_eq("rtr_unexpected", bus.rtr_data, 0);
        end else begin
          cur = exp_rtr.pop_front();
          in_pkt = 1;
          idx = 0;
          check_eq("grant_send", bus.grant, cur.src);
          if (strict && have_prev && prev_phase == phase)
            check_eq("hdr_interval", cyc - last_hdr, last_n + GAP + 1 + int'(cur.n));
          last_hdr = cyc;
          last_n = int'(cur.n);
          have_prev = 1;
          prev_phase = phase;
        end
      end
      if (in_pkt) begin
        check_eq("rtr_byte", {bus.rtr_pkt_valid, bus.rtr_data},
                 {(idx < int'(cur.n) - 1), cur.b[8*idx +: 8]});
        if (!bus.busy) begin
          idx++;
          if (idx == int'(cur.n)) begin
            in_pkt = 0;
            done_due = 1;
          end
        end
      end
    end
  end

  task automatic do_reset(input int cycles);
    @(negedge clk);
    #2 rst = 1'b1;
    model_last = 2;
    repeat (cycles) @(negedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (!(exp_load.size() == 0 && exp_rtr.size() == 0 && !in_pkt && !done_due &&
             sq[0].size() == 0 && sq[1].size() == 0 && sq[2].size() == 0) && t < 4000) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (t >= 4000) $display("phase %s did not drain", name);
    check_eq({"drain_", name}, (t < 4000), 1);
    repeat (GAP + 3) @(negedge clk);
  endtask

  initial begin
    int t;
    bit found;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;

    // Single source, len 10 to port 1.
    @(negedge clk);
    phase = 1; strict = 1; gaps = 0; busy_mode = 0;
    add_pkt(mk_pkt(1, 6'd10, 2'd1, 0));
    commit();
    wait_done("single");

    // Fresh arbitration: sources 0 and 2 alternate with len-4 packets.
    do_reset(2);
    @(negedge clk);
    phase = 2; strict = 1;
    for (int k = 0; k < 2; k++) begin
      add_pkt(mk_pkt(0, 6'd4, 2'($urandom_range(0, 2)), 0));
      add_pkt(mk_pkt(2, 6'd4, 2'($urandom_range(0, 2)), 0));
    end
    commit();
    wait_done("alternate");

    // len 16 to port 2 with a 3-cycle stall on byte 5.
    @(negedge clk);
    phase = 3; strict = 0; busy_mode = 2;
    add_pkt(mk_pkt(2, 6'd16, 2'd2, 0));
    commit();
    wait_done("busy_stall");
    busy_mode = 0;

    // Drop packet followed by another requester.
    @(negedge clk);
    phase = 4;
    add_pkt(mk_pkt(0, 6'd3, 2'd3, 0));
    add_pkt(mk_pkt(1, 6'd2, 2'd0, 0));
    commit();
    wait_done("drop");

    // Corrupted parity is flagged but forwarded untouched.
    @(negedge clk);
    phase = 5;
    add_pkt(mk_pkt(1, 6'd5, 2'd0, 1));
    commit();
    wait_done("parity");

    // Random mix: all sources, gaps, busy, drops, bad parity, len 0.
    @(negedge clk);
    phase = 6; gaps = 1; busy_mode = 1;
    add_pkt(mk_pkt(0, 6'd0, 2'd1, 0));
    for (int k = 0; k < 3; k++)
      for (int s = 0; s < 3; s++)
        add_pkt(mk_pkt(s, 6'($urandom_range(0, 20)), 2'($urandom_range(0, 3)),
                       ($urandom_range(0, 3) == 0)));
    commit();
    wait_done("random");
    gaps = 0; busy_mode = 0;

    // Reset in the middle of LOAD, then the packet is resent from its header.
    @(negedge clk);
    phase = 7;
    add_pkt(mk_pkt(0, 6'd8, 2'd1, 0));
    commit();
    found = 0;
    t = 0;
    while (!found && t < 200) begin
      @(negedge clk);
      t++;
      if (bus.src_ready[0]) found = 1;
    end
    check_eq("reset_wait_load", found, 1);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    model_last = 2;
    #1;
    check_eq("async_reset_outputs",
             {bus.src_ready, bus.rtr_data, bus.rtr_pkt_valid, bus.grant,
              bus.pkt_done, bus.drop, bus.par_err},
             {3'b000, 8'h00, 1'b0, 2'd3, 3'b000});
    @(negedge clk);
    #2 rst = 1'b0;
    wait_done("reset_restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
